arty_reset_sequencer: RTL and testbench
=======================================

// Module: arty_reset_sequencer
// PURPOSE
//  Board-level reset controller. Sits between the global pushbutton reset and the MMCM, and the clocked subsystems.
//  Waits for a stable MMCM lock, then releases N active-high domain resets one at a time with a fixed gap.
//  Re-asserts all domain resets on lock loss or on a software re-sequence request, then repeats the sequence.
// PARAMETERS
//  c_NUM_DOMAINS        4     number of domain reset outputs (>=1); bit 0 is released first
//  c_LOCK_STABLE_CYCLES 1024  consecutive synchronized-lock cycles required before the first release (>=1)
//  c_STAGE_GAP_CYCLES   16    cycles between successive releases; also the minimum hold after a software request (>=1)
// PORTS
//  i_clk_mhz        in   1              sequencer clock
//  i_rstn_global    in   1              reset, asynchronous, active-low
//  i_mmcm_locked    in   1              MMCM lock, asynchronous to i_clk_mhz; 2-flop synchronized internally (s_locked)
//  i_sw_rst_req     in   1              1-cycle pulse: restart the full sequence
//  i_clr_lock_lost  in   1              1-cycle pulse: clear o_lock_lost
//  o_rst_domain     out  c_NUM_DOMAINS  active-high domain resets, registered
//  o_seq_done       out  1              high while all domains are released (S_RUN)
//  o_lock_lost      out  1              sticky flag: lock dropped after sequencing had begun
// BEHAVIOUR
//  - Reset (i_rstn_global=0), applied asynchronously:
//    o_rst_domain = all 1s, o_seq_done = 0, o_lock_lost = 0, lock synchronizer = 0, counters = 0, state = S_WAIT_LOCK.
//  - All outputs are registered. Domain resets are asserted all together and released strictly in index order.
//  - Counter widths are $clog2(max+1) of their limit. Counters saturate and never wrap.
//  - S_WAIT_LOCK: stable counter increments on each cycle with s_locked=1 and clears to 0 when s_locked=0.
//    Let E be the first cycle in which s_locked=1. If lock stays high, o_rst_domain[0] goes low in cycle E+c_LOCK_STABLE_CYCLES.
//    The state moves to S_RELEASE at the same time.
//  - S_RELEASE: gap counter runs. Bit k goes low exactly c_STAGE_GAP_CYCLES cycles after bit k-1.
//    That is, bit k is low from cycle E+L+k*G.
//    When the last bit goes low, o_seq_done goes to 1 in the same cycle, and the state moves to S_RUN.
//  - S_RUN: o_rst_domain = 0, o_seq_done = 1. The block stays here until lock loss or a software request.
//  - Lock loss (s_locked=0 in S_RELEASE or S_RUN):
//    next cycle o_rst_domain = all 1s, o_seq_done = 0, o_lock_lost = 1, state goes to S_WAIT_LOCK with counters cleared.
//  - Software request (i_sw_rst_req=1 in S_RELEASE or S_RUN, lock still high):
//    next cycle o_rst_domain = all 1s, o_seq_done = 0, state goes to S_HOLD.
//  - S_HOLD: resets held for c_STAGE_GAP_CYCLES cycles, then state goes to S_WAIT_LOCK and the full lock-stable count restarts.
//    Lock loss in S_HOLD goes to S_WAIT_LOCK immediately and sets o_lock_lost.
//  - i_sw_rst_req in S_WAIT_LOCK has no effect; the stable count is not restarted.
//  - Priority when events coincide: lock loss > software request > sequencing progress.
//    Lock loss and i_sw_rst_req in the same cycle are handled as lock loss only.
//  - o_lock_lost: set on lock loss outside S_WAIT_LOCK, cleared by i_clr_lock_lost. If set and clear coincide, set wins.
//    Lock dropping during S_WAIT_LOCK does not set the flag.
//  - Reset mid-operation: asserting i_rstn_global in any state forces the reset values immediately, with no clock needed.
//  - Reset release: the first state or counter change occurs no earlier than the 3rd rising edge after release,
//    because of the 2-flop lock synchronizer.
// TESTING (c_NUM_DOMAINS=4, c_LOCK_STABLE_CYCLES=8, c_STAGE_GAP_CYCLES=3)
//  1. Lock held high before reset release.
//     -> bits 0..3 go low at E+8, E+11, E+14, E+17; o_seq_done=1 from E+17; o_rst_domain=4'b0000 after that.
//  2. Lock glitches low for 1 cycle at E+5.
//     -> stable count restarts; bit 0 goes low 8 cycles after s_locked returns high; o_lock_lost stays 0.
//  3. Lock drops in S_RUN.
//     -> next cycle o_rst_domain=4'b1111, o_seq_done=0, o_lock_lost=1.
//     -> relock: full sequence repeats. i_clr_lock_lost pulse then sets o_lock_lost=0.
//  4. i_sw_rst_req pulse in S_RUN.
//     -> 4'b1111 held for 3 cycles, then 8 stable cycles, then the same 3-cycle-gap release; o_lock_lost stays 0.
//  5. i_sw_rst_req and lock loss in the same cycle during S_RELEASE (after bit 1 is released).
//     -> all bits 1, o_lock_lost=1, state S_WAIT_LOCK, S_HOLD not entered.
//  6. i_rstn_global pulsed low mid-gap, asynchronously to the clock.
//     -> outputs return to 4'b1111/0/0 with no clock edge; the sequence restarts after release.
//     Also check that i_clr_lock_lost and a lock-loss set in the same cycle leave o_lock_lost=1.

Source files
------------

// File: rtl/arty_reset_sequencer.sv
// Board reset sequencer: waits for a stable MMCM lock, then releases the domain
// resets one by one in index order, re-sequencing on lock loss or software request.
module arty_reset_sequencer #(
    parameter int c_NUM_DOMAINS        = 4,
    parameter int c_LOCK_STABLE_CYCLES = 1024,
    parameter int c_STAGE_GAP_CYCLES   = 16
) (
    input  logic                     i_clk_mhz,
    input  logic                     i_rstn_global,
    input  logic                     i_mmcm_locked,
    input  logic                     i_sw_rst_req,
    input  logic                     i_clr_lock_lost,
    output logic [c_NUM_DOMAINS-1:0] o_rst_domain,
    output logic                     o_seq_done,
    output logic                     o_lock_lost
);

    localparam int c_STABLE_W = $clog2(c_LOCK_STABLE_CYCLES + 1);
    localparam int c_GAP_W    = $clog2(c_STAGE_GAP_CYCLES + 1);

    localparam logic [c_STABLE_W-1:0] c_STABLE_LAST = c_STABLE_W'(c_LOCK_STABLE_CYCLES - 1);
    localparam logic [c_STABLE_W-1:0] c_STABLE_MAX  = c_STABLE_W'(c_LOCK_STABLE_CYCLES);
    localparam logic [c_GAP_W-1:0]    c_GAP_LAST    = c_GAP_W'(c_STAGE_GAP_CYCLES - 1);
    localparam logic [c_GAP_W-1:0]    c_GAP_MAX     = c_GAP_W'(c_STAGE_GAP_CYCLES);
    localparam logic [c_NUM_DOMAINS-1:0] c_ALL_ON   = {c_NUM_DOMAINS{1'b1}};

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_RELEASE   = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
    localparam logic [1:0] S_HOLD      = 2'd3;

    logic                     lock_meta_q, lock_meta_d;
    logic                     lock_sync_q, lock_sync_d;
    logic [1:0]               state_q, state_d;
    logic [c_STABLE_W-1:0]    stable_cnt_q, stable_cnt_d;
    logic [c_GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [c_NUM_DOMAINS-1:0] rst_q, rst_d;
    logic                     seq_done_q, seq_done_d;
    logic                     lock_lost_q, lock_lost_d;
    logic                     s_locked;
    logic [c_NUM_DOMAINS-1:0] next_rel;

    assign s_locked = lock_sync_q;

    always_comb begin
        lock_meta_d  = i_mmcm_locked;
        lock_sync_d  = lock_meta_q;
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        rst_d        = rst_q;
        // Clear is applied first so a coincident set below wins.
        lock_lost_d  = lock_lost_q & ~i_clr_lock_lost;
        next_rel     = '0;

        case (state_q)
            S_WAIT_LOCK: begin
                if (s_locked) begin
                    if (stable_cnt_q == c_STABLE_LAST) begin
                        next_rel     = c_ALL_ON << 1;
                        rst_d        = next_rel;
                        stable_cnt_d = '0;
                        gap_cnt_d    = '0;
                        state_d      = (next_rel == '0) ? S_RUN : S_RELEASE;
                    end else if (stable_cnt_q != c_STABLE_MAX) begin
                        stable_cnt_d = stable_cnt_q + c_STABLE_W'(1);
                    end
                end else begin
                    stable_cnt_d = '0;
                end
            end
            S_RELEASE, S_RUN, S_HOLD: begin
                if (!s_locked) begin
                    state_d      = S_WAIT_LOCK;
                    rst_d        = c_ALL_ON;
                    stable_cnt_d = '0;
                    gap_cnt_d    = '0;
                    lock_lost_d  = 1'b1;
                end else if (i_sw_rst_req && (state_q != S_HOLD)) begin
                    state_d   = S_HOLD;
                    rst_d     = c_ALL_ON;
                    gap_cnt_d = '0;
                end else if (state_q == S_RELEASE) begin
                    if (gap_cnt_q == c_GAP_LAST) begin
                        next_rel  = rst_q << 1;
                        rst_d     = next_rel;
                        gap_cnt_d = '0;
                        if (next_rel == '0) begin
                            state_d = S_RUN;
                        end
                    end else if (gap_cnt_q != c_GAP_MAX) begin
                        gap_cnt_d = gap_cnt_q + c_GAP_W'(1);
                    end
                end else if (state_q == S_HOLD) begin
                    // Hold expires into a fresh lock-stable count.
                    if (gap_cnt_q == c_GAP_LAST) begin
                        state_d      = S_WAIT_LOCK;
                        gap_cnt_d    = '0;
                        stable_cnt_d = '0;
                    end else if (gap_cnt_q != c_GAP_MAX) begin
                        gap_cnt_d = gap_cnt_q + c_GAP_W'(1);
                    end
                end
            end
            default: begin
                state_d      = S_WAIT_LOCK;
                rst_d        = c_ALL_ON;
                stable_cnt_d = '0;
                gap_cnt_d    = '0;
            end
        endcase

        seq_done_d = (state_d == S_RUN);
    end

    always_ff @(posedge i_clk_mhz or negedge i_rstn_global) begin
        if (!i_rstn_global) begin
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            state_q      <= S_WAIT_LOCK;
            stable_cnt_q <= '0;
            gap_cnt_q    <= '0;
            rst_q        <= c_ALL_ON;
            seq_done_q   <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            lock_meta_q  <= lock_meta_d;
            lock_sync_q  <= lock_sync_d;
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            rst_q        <= rst_d;
            seq_done_q   <= seq_done_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    assign o_rst_domain = rst_q;
    assign o_seq_done   = seq_done_q;
    assign o_lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_arty_reset_sequencer.sv
// Bench for arty_reset_sequencer: a timeline reference model predicts every cycle's
// outputs into a queue; a monitor pops and compares on each falling edge.
module tb_arty_reset_sequencer;

    localparam int N = 4;
    localparam int L = 8;
    localparam int G = 3;
    localparam int W = N + 2;

    localparam int M_WAIT = 0;
    localparam int M_SEQ  = 1;
    localparam int M_HOLD = 2;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic         lock = 1'b0;
    logic         sw   = 1'b0;
    logic         clr  = 1'b0;
    logic [N-1:0] rst_dom;
    logic         done;
    logic         lost;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    arty_reset_sequencer #(
        .c_NUM_DOMAINS       (N),
        .c_LOCK_STABLE_CYCLES(L),
        .c_STAGE_GAP_CYCLES  (G)
    ) dut (
        .i_clk_mhz      (clk),
        .i_rstn_global  (rstn),
        .i_mmcm_locked  (lock),
        .i_sw_rst_req   (sw),
        .i_clr_lock_lost(clr),
        .o_rst_domain   (rst_dom),
        .o_seq_done     (done),
        .o_lock_lost    (lost)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got rst/done/lost=%b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts falling edges until o_rst_domain shows val; -1 on timeout.
    task automatic wait_rst(input logic [N-1:0] val, input int max, input string name, output int cnt);
        cnt = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (rst_dom === val) begin
                cnt = i + 1;
                break;
            end
        end
        if (cnt < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout waiting for rst=%b, got %b", name, val, rst_dom);
        end
    endtask

    // Reference model: outputs derived from release timestamps, not from counters.
    initial begin : model
        int t;
        int phase;
        int run_len;
        int base;
        int hold_end;
        bit lost_m;
        bit h1;
        bit h2;
        bit s;
        logic [N-1:0] r;
        logic dn;
        t = 0; phase = M_WAIT; run_len = 0; base = 0; hold_end = 0;
        lost_m = 0; h1 = 0; h2 = 0; s = 0;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                t = 0; phase = M_WAIT; run_len = 0; lost_m = 0; h1 = 0; h2 = 0;
                exp_q.delete();
            end else begin
                t++;
                s  = h2;
                h2 = h1;
                h1 = lock;
                if (clr) lost_m = 0;
                if (phase == M_WAIT) begin
                    if (s) begin
                        run_len++;
                        if (run_len == L) begin
                            phase = M_SEQ;
                            base  = t;
                        end
                    end else begin
                        run_len = 0;
                    end
                end else if (!s) begin
                    phase   = M_WAIT;
                    run_len = 0;
                    lost_m  = 1;
                end else if (sw && phase == M_SEQ) begin
                    phase    = M_HOLD;
                    hold_end = t + G;
                end else if (phase == M_HOLD && t == hold_end) begin
                    phase   = M_WAIT;
                    run_len = 0;
                end
                for (int k = 0; k < N; k++)
                    r[k] = (phase == M_SEQ) ? (t < base + k * G) : 1'b1;
                dn = (phase == M_SEQ) && (r == '0);
                exp_q.push_back({r, dn, lost_m});
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("reset_vals", {rst_dom, done, lost}, {{N{1'b1}}, 2'b00});
            end else if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
            end else begin
                check("cycle", {rst_dom, done, lost}, exp_q.pop_front());
            end
        end
    end

    initial begin : stimulus
        int c;
        int low_cnt;
        low_cnt = 0;

        // 1: lock high before reset release
        lock = 1'b1;
        tick(2);
        #2 rstn = 1'b1;
        wait_rst(4'b1110, 40, "t1_bit0", c);
        check_int("t1_bit0_latency", c, 10);
        wait_rst(4'b0000, 40, "t1_all", c);
        check_int("t1_all_latency", c, 9);
        tick(3);

        // 2: one-cycle lock glitch during the stable count
        @(negedge clk);
        #2 rstn = 1'b0;
        tick(2);
        #2 rstn = 1'b1;
        tick(5);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        tick(30);
        check_int("t2_lost_stays0", int'(lost), 0);

        // 3: lock loss in S_RUN, relock, clear flag
        lock = 1'b0;
        tick(4);
        check_int("t3_lost_set", int'(lost), 1);
        lock = 1'b1;
        wait_rst(4'b0000, 40, "t3_relock", c);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check_int("t3_lost_cleared", int'(lost), 0);

        // 4: software request in S_RUN
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        check("t4_hold", {rst_dom, done, lost}, {{N{1'b1}}, 2'b00});
        wait_rst(4'b1110, 40, "t4_bit0", c);
        check_int("t4_bit0_latency", c, 11);
        wait_rst(4'b0000, 40, "t4_all", c);
        check_int("t4_all_latency", c, 9);

        // 5: sw request and lock loss land on the same edge during release
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        wait_rst(4'b1100, 40, "t5_bit1", c);
        lock = 1'b0;
        tick(2);
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        check("t5_coincide", {rst_dom, done, lost}, {{N{1'b1}}, 2'b01});
        tick(3);
        lock = 1'b1;
        wait_rst(4'b1110, 40, "t5_relock", c);
        check_int("t5_no_hold_latency", c, 10);
        wait_rst(4'b0000, 40, "t5_all", c);

        // set and clear of the lock-lost flag on the same edge
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check_int("t5_lost_cleared", int'(lost), 0);
        lock = 1'b0;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check_int("set_beats_clear", int'(lost), 1);
        lock = 1'b1;

        // 6: asynchronous reset mid-gap, checked before any clock edge
        wait_rst(4'b1110, 40, "t6_bit0", c);
        #2 rstn = 1'b0;
        #1 check("t6_async_reset", {rst_dom, done, lost}, {{N{1'b1}}, 2'b00});
        tick(2);
        #2 rstn = 1'b1;
        wait_rst(4'b1110, 40, "t6_restart", c);
        check_int("t6_restart_latency", c, 10);

        // randomized lock drops, sw requests and clears
        for (int i = 0; i < 1500; i++) begin
            if (low_cnt > 0) begin
                low_cnt--;
                lock = 1'b0;
            end else begin
                lock = 1'b1;
                if ($urandom_range(0, 59) == 0) low_cnt = $urandom_range(1, 4);
            end
            sw  = ($urandom_range(0, 24) == 0);
            clr = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        sw   = 1'b0;
        clr  = 1'b0;
        lock = 1'b1;
        tick(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
